mem_access_unit: RTL and testbench

- Load/store unit in the MEM stage, directly upstream of the word-wide data memory.
- Handles byte, halfword and word loads/stores for the pipeline.
- Converts sub-word stores into a two-cycle read-modify-write (RMW) and stalls the pipeline during it.
- Extracts and sign/zero-extends sub-word load data; detects misaligned accesses and captures the faulting address.

---
 rtl/mem_access_unit_pkg.sv | 43 ++++
 rtl/mem_access_unit_load_extract.sv | 40 ++++
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: operation and state
// encodings, plus small decode helpers used by the top and its extractor.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  // True for any encoding that names a real access (OP_NONE and holes excluded).
  function automatic logic op_is_defined(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  // Halfword ops need addr[0]=0, word ops need addr[1:0]=0; bytes never fault.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = addr_lo[0];
      OP_LW, OP_SW:         bad = (addr_lo != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Load data extraction: picks the addressed byte/halfword out of a memory word
// and sign- or zero-extends it. Purely combinational so it can sit on any
// read path (cached MEM stage today, uncached I/O later).
module load_extract
  import mem_access_unit_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [1:0]  w_byte_pos;
  logic        w_half_pos;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Big-endian simply mirrors the lane index within the word.
  assign w_byte_pos = LITTLE_ENDIAN ? i_addr_lo    : ~i_addr_lo;
  assign w_half_pos = LITTLE_ENDIAN ? i_addr_lo[1] : ~i_addr_lo[1];

  assign w_byte = i_word[{w_byte_pos, 3'b000} +: 8];
  assign w_half = i_word[{w_half_pos, 4'b0000} +: 16];

  // Extend the selected lane according to the load flavour.
  always_comb begin
    o_data = '0;
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'd0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'd0, w_half};
      OP_LW:   o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide data memory. Loads and
// word stores complete in one cycle; byte/halfword stores become a read
// (merge captured in r_merge, pipeline stalled) followed by a full-word write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_BITS     = 11,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] bad_vaddr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  state_e      r_state;
  state_e      w_state_next;
  logic [31:0] r_merge;
  logic [31:0] r_bad_vaddr;

  logic        w_op_defined;
  logic        w_misalign;
  logic        w_access;
  logic        w_is_load;
  logic        w_is_sub_store;
  logic        w_is_sb;
  logic [31:0] w_ext_data;
  logic [31:0] w_merged;
  logic [3:0]  w_lane_sel;
  logic [1:0]  w_st_byte_pos;
  logic        w_st_half_pos;

  // Request decode: undefined ops behave exactly like no request.
  assign w_op_defined   = req_valid && op_is_defined(req_op);
  assign w_misalign     = w_op_defined && op_misaligned(req_op, req_addr[1:0]);
  assign w_access       = w_op_defined && !w_misalign;
  assign w_is_load      = op_is_load(req_op);
  assign w_is_sb        = (req_op == OP_SB);
  assign w_is_sub_store = (req_op == OP_SB) || (req_op == OP_SH);

  // Word address split at ADDR_BITS purely for readability; high bits pass
  // through untouched and the memory aliases them.
  assign mem_addr = {req_addr[31:ADDR_BITS], req_addr[ADDR_BITS-1:2], 2'b00};
  assign misalign = w_misalign;
  assign bad_vaddr = r_bad_vaddr;

  load_extract #(
    .LITTLE_ENDIAN (LITTLE_ENDIAN)
  ) u_load_extract (
    .i_op      (req_op),
    .i_addr_lo (req_addr[1:0]),
    .i_word    (mem_rdata),
    .o_data    (w_ext_data)
  );

  // Only a granted load in IDLE drives rdata; everything else reads as zero.
  assign rdata = (r_state == ST_IDLE && w_access && w_is_load) ? w_ext_data : 32'd0;

  // Store merge: replace the addressed lane(s) of the read word with store data.
  assign w_st_byte_pos = LITTLE_ENDIAN ? req_addr[1:0] : ~req_addr[1:0];
  assign w_st_half_pos = LITTLE_ENDIAN ? req_addr[1]   : ~req_addr[1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      // Within a halfword field the even lane always holds wdata[7:0].
      localparam bit HIGH_IN_HALF = (gi % 2) == 1;
      logic [7:0] w_lane_data;
      assign w_lane_sel[gi] = w_is_sb ? (w_st_byte_pos == 2'(gi))
                                      : (w_st_half_pos == 1'(gi / 2));
      assign w_lane_data = (!w_is_sb && HIGH_IN_HALF) ? req_wdata[15:8] : req_wdata[7:0];
      assign w_merged[8*gi +: 8] = w_lane_sel[gi] ? w_lane_data : mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Next-state and memory-control decode; stall never looks at mem_rdata.
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_is_load) begin
            mem_read = 1'b1;
          end else if (w_is_sub_store) begin
            mem_read     = 1'b1;
            stall        = 1'b1;
            w_state_next = ST_RMW_WR;
          end else begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end
        end
      end
      ST_RMW_WR: begin
        mem_write    = 1'b1;
        mem_wdata    = r_merge;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any pending RMW write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the merged word during the read half of a sub-word store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_merge <= 32'd0;
    end else if (r_state == ST_IDLE && w_access && w_is_sub_store) begin
      r_merge <= w_merged;
    end
  end

  // Remember the address of the most recent misaligned request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bad_vaddr <= 32'd0;
    end else if (w_misalign) begin
      r_bad_vaddr <= req_addr;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes one hand-computed
// expectation per cycle, a negedge monitor pops and compares DUT outputs.
module tb_mem_access_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign;
  logic [31:0] bad_vaddr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:511];

  typedef struct {
    string       name;
    logic        stall;
    logic        mis;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic [31:0] bv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_bv;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_BITS     (11),
    .LITTLE_ENDIAN (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rdata     (rdata),
    .misalign  (misalign),
    .bad_vaddr (bad_vaddr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Behavioural word memory: combinational read, commit at posedge.
  assign mem_rdata = mem[mem_addr[10:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[10:2]] <= mem_wdata;
  end

  task automatic chk(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %08h expected %08h", nm, field, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
        chk(e.name, "misalign", {31'd0, misalign}, {31'd0, e.mis});
        chk(e.name, "mem_read", {31'd0, mem_read}, {31'd0, e.rd});
        chk(e.name, "mem_write", {31'd0, mem_write}, {31'd0, e.wr});
        if (e.wr) chk(e.name, "mem_wdata", mem_wdata, e.wdata);
        if (e.chk_rdata) chk(e.name, "rdata", rdata, e.rdata);
        chk(e.name, "bad_vaddr", bad_vaddr, e.bv);
        $display("[TB] txn %-14s op=%0d addr=%08h rdata=%08h wr=%0b wdata=%08h",
                 e.name, req_op, req_addr, rdata, mem_write, mem_wdata);
      end
    end
  end

  task automatic drive(input string nm, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_st, input logic e_mis, input logic e_rd,
                       input logic e_wr, input logic [31:0] e_wd,
                       input logic e_chk, input logic [31:0] e_rdata);
    exp_t e;
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    e.name = nm; e.stall = e_st; e.mis = e_mis; e.rd = e_rd; e.wr = e_wr;
    e.wdata = e_wd; e.chk_rdata = e_chk; e.rdata = e_rdata; e.bv = exp_bv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input string nm, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] exp);
    drive(nm, 1'b1, op, a, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, exp);
  endtask

  // Sub-word store: stalled read cycle, then the merged word write.
  task automatic store_sub(input string nm, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] merged);
    drive({nm, "_rd"}, 1'b1, op, a, wd, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    drive({nm, "_wr"}, 1'b1, op, a, wd, 1'b0, 1'b0, 1'b0, 1'b1, merged, 1'b0, 32'd0);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[32'h30 >> 2] = 32'hCAFEF00D;
    mem[32'h40 >> 2] = 32'h11223344;
    exp_bv    = 32'd0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_NONE;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    @(posedge clk);
    #1;
    drive("reset_state", 1'b0, OP_NONE, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'd0);
    reset = 1'b0;

    drive("idle", 1'b0, OP_LW, 32'h10, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'd0);
    drive("op_none", 1'b1, OP_NONE, 32'h21, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'd0);
    drive("undef_op", 1'b1, 4'hF, 32'h21, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'd0);

    // Misaligned load: nothing issued, address captured next edge.
    drive("lw_mis", 1'b1, OP_LW, 32'h21, 32'd0, 0, 1, 0, 0, 32'd0, 1, 32'd0);
    exp_bv = 32'h21;
    drive("after_mis", 1'b0, OP_NONE, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'd0);

    // Reset during the write half of an sb: no write, state and bad_vaddr cleared.
    drive("sb_rst_rd", 1'b1, OP_SB, 32'h41, 32'h99, 1, 0, 1, 0, 32'd0, 0, 32'd0);
    reset  = 1'b1;
    exp_bv = 32'd0;
    drive("rst_in_rmw", 1'b0, OP_NONE, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'd0);
    reset = 1'b0;
    load("lw_after_rst", OP_LW, 32'h40, 32'h11223344);

    // Word store then word load.
    drive("sw_10", 1'b1, OP_SW, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'd0);
    load("lw_10", OP_LW, 32'h10, 32'hDEADBEEF);

    // Sub-word loads from 0xDEADBEEF.
    load("lb_13", OP_LB, 32'h13, 32'hFFFFFFDE);
    load("lbu_13", OP_LBU, 32'h13, 32'h000000DE);
    load("lb_10", OP_LB, 32'h10, 32'hFFFFFFEF);
    load("lbu_11", OP_LBU, 32'h11, 32'h000000BE);
    load("lh_12", OP_LH, 32'h12, 32'hFFFFDEAD);
    load("lhu_10", OP_LHU, 32'h10, 32'h0000BEEF);
    load("lh_10", OP_LH, 32'h10, 32'hFFFFBEEF);

    // Byte RMW into lane 1.
    store_sub("sb_11", OP_SB, 32'h11, 32'h00000055, 32'hDEAD55EF);
    load("lw_10_sb", OP_LW, 32'h10, 32'hDEAD55EF);

    // Back-to-back halfword stores into a zero word.
    store_sub("sh_20", OP_SH, 32'h20, 32'h00001234, 32'h00001234);
    store_sub("sh_22", OP_SH, 32'h22, 32'h0000ABCD, 32'hABCD1234);
    load("lw_20", OP_LW, 32'h20, 32'hABCD1234);

    // Misaligned halfword store: no write, word untouched.
    drive("sh_mis", 1'b1, OP_SH, 32'h33, 32'h7777, 0, 1, 0, 0, 32'd0, 1, 32'd0);
    exp_bv = 32'h33;
    load("lw_30", OP_LW, 32'h30, 32'hCAFEF00D);
    drive("final_idle", 1'b0, OP_NONE, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'd0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
